apb_arb_master: RTL
===================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of ACCESS cycles without pready before a forced error completion; 0 disables the timeout.
REQ-002 SHALL have port pclk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port presetn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  in  2  per-requester request valid; bit n belongs to requester n.
REQ-005 SHALL have port req_ready  out  2  per-requester request accept.
REQ-006 SHALL have port req_write  in  2  per-requester direction; 1 means write.
REQ-007 SHALL have port req_addr  in  2x12  per-requester peripheral offset.
REQ-008 SHALL have port req_wdata  in  2x32  per-requester write data.
REQ-009 SHALL have port req_strb  in  2x4  per-requester write strobes.
REQ-010 SHALL have port req_prot  in  2x3  per-requester protection attributes.
REQ-011 SHALL have port rsp_valid  out  2  per-requester response pulse.
REQ-012 SHALL have port rsp_rdata  out  32  response read data, shared by both requesters.
REQ-013 SHALL have port rsp_err  out  1  response error, shared by both requesters.
REQ-014 SHALL have ports psel, penable, pwrite  out  1 each, paddr  out  12, pwdata  out  32, pstrb  out  4, pprot  out  3: the APB master side.
REQ-015 SHALL have ports prdata  in  32, pready  in  1, pslverr  in  1: the APB completer response.

Function
REQ-016 SHALL implement three states, IDLE, SETUP and ACCESS, with IDLE as the reset state.
REQ-017 SHALL, in IDLE with any req_valid high, grant one requester and drive req_ready[g]=1 combinationally in that cycle; the request is accepted on req_valid[g] & req_ready[g].
REQ-018 SHALL arbitrate round-robin: a 1-bit pointer names the priority requester, and on each grant it moves to the non-granted requester.
REQ-019 SHALL, on acceptance, register write, addr, wdata, strb and prot and move to SETUP.
REQ-020 SHALL hold req_ready at 0 outside IDLE and when no request is valid.
REQ-021 SHALL, in SETUP, drive psel=1 and penable=0, then go unconditionally to ACCESS.
REQ-022 SHALL, in ACCESS, drive psel=1 and penable=1 and stay in ACCESS until pready=1 or the timeout fires.
REQ-023 SHALL hold paddr, pwrite, pwdata, pstrb and pprot stable from SETUP through the final ACCESS cycle.
REQ-024 SHALL drive pstrb=0 on reads.
REQ-025 SHALL drive all APB outputs to 0 in IDLE.
REQ-026 SHALL, on the ACCESS cycle with pready=1, register rsp_valid[g]=1 for exactly one cycle in the next cycle, with rsp_rdata = prdata for reads or 0 for writes, and rsp_err = pslverr; the state returns to IDLE.
REQ-027 SHALL count ACCESS cycles with a counter cleared on entry to SETUP.
REQ-028 SHALL, when TIMEOUT>0 and the count reaches TIMEOUT with pready=0, drop psel and penable, return to IDLE and complete with rsp_err=1 and rsp_rdata=0.
REQ-029 SHALL give pready priority over the timeout when both occur in the same cycle.
REQ-030 SHALL hold rsp_rdata and rsp_err at 0 when no rsp_valid bit is set.
REQ-031 SHALL assert at most one rsp_valid bit per cycle.
REQ-032 SHALL meet these latencies: minimum 3 cycles per transfer (IDLE, SETUP, one ACCESS); the response appears 1 cycle after the completing ACCESS; a new grant can occur in the same cycle the response is presented.
REQ-033 SHALL ignore pready, pslverr and prdata outside ACCESS.
REQ-034 SHALL ignore a req_valid deassertion after acceptance; the accepted transfer always completes.

Reset
REQ-035 SHALL, while presetn=0 (asynchronously, including mid-transfer), force state=IDLE, every output to 0, pointer=0 (requester 0 has priority first) and the counter to 0.
REQ-036 SHALL NOT issue a response for a transfer aborted by reset.

Verification
REQ-037 Single read: req_valid=01, addr0=0x014, write=0, pready=1 in the first ACCESS, prdata=0xDEADBEEF -> SETUP then ACCESS; rsp_valid=01 one cycle later with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-038 Contention: req_valid=11 held continuously after reset -> grants alternate 0,1,0,1 and paddr follows each granted requester.
REQ-039 Wait states: write addr=0x100, wdata=0x12345678, strb=0xF, pready low for 3 ACCESS cycles -> psel/penable high for 4 cycles with paddr/pwdata stable; rsp_err=pslverr and rsp_rdata=0.
REQ-040 Timeout: TIMEOUT=4, pready held 0 -> after 4 ACCESS cycles psel drops; rsp_valid pulses with rsp_err=1 and rsp_rdata=0; pready=1 on the 4th cycle instead -> normal completion.
REQ-041 Reset mid-ACCESS: presetn=0 asynchronously -> psel=penable=0 immediately; no rsp_valid; the next grant goes to requester 0.
REQ-042 Read strobe: read with req_strb=0xF -> pstrb=0 throughout the transfer.

Source files
------------

// File: rtl/apb_arb_master_if.sv
// Requester-side request/response lanes plus the APB master/completer bus of apb_arb_master.
// Modport master is the arbiter's view; modport slave is the view of requesters and the completer.
interface apb_arb_master_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][11:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_strb;
  logic [1:0][2:0]  req_prot;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [11:0]      paddr;
  logic [31:0]      pwdata;
  logic [3:0]       pstrb;
  logic [2:0]       pprot;
  logic [31:0]      prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_arb_master.sv
// Two-requester round-robin APB master: IDLE/SETUP/ACCESS, >=3 cycles per transfer, response 1 cycle after completion.
// Requests are stalled (req_ready=0) outside IDLE; a hung completer is cut off after TIMEOUT ACCESS cycles.
module apb_arb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_arb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t      r_state;
  logic        r_ptr;
  logic        r_gnt;
  logic [CW-1:0] r_cnt;
  logic        r_psel;
  logic        r_penable;
  logic        r_write;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [2:0]  r_prot;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_take;
  logic        w_gnt;
  logic        w_timeout;

  // Pointer only matters under contention; a lone requester wins outright.
  assign w_gnt     = (&bus.req_valid) ? r_ptr : bus.req_valid[1];
  assign w_take    = (r_state == IDLE) && (|bus.req_valid);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  assign bus.req_ready = (w_take && presetn) ? (2'b01 << w_gnt) : 2'b00;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_gnt       <= 1'b0;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_prot      <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_gnt     <= w_gnt;
            r_ptr     <= ~w_gnt;
            r_write   <= bus.req_write[w_gnt];
            r_addr    <= bus.req_addr[w_gnt];
            r_wdata   <= bus.req_wdata[w_gnt];
            r_strb    <= bus.req_write[w_gnt] ? bus.req_strb[w_gnt] : 4'h0;
            r_prot    <= bus.req_prot[w_gnt];
            r_cnt     <= '0;
            r_psel    <= 1'b1;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // pready outranks a timeout landing on the same cycle.
          if (bus.pready || w_timeout) begin
            r_rsp_valid <= 2'b01 << r_gnt;
            r_rsp_rdata <= (bus.pready && !r_write) ? bus.prdata : 32'h0;
            r_rsp_err   <= bus.pready ? bus.pslverr : 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_prot      <= '0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_write;
  assign bus.paddr     = r_addr;
  assign bus.pwdata    = r_wdata;
  assign bus.pstrb     = r_strb;
  assign bus.pprot     = r_prot;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule
